// File: rtl/mc_cu_pkg.sv
// mc_cu_pkg: state, opcode, func and select encodings
// shared by the multicycle control unit and its decoder.
package mc_cu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_REG = 2'b10;
    localparam logic [1:0] PCS_JMP = 2'b11;

    typedef struct packed {
        logic i_add;
        logic i_sub;
        logic i_and;
        logic i_or;
        logic i_xor;
        logic i_sll;
        logic i_srl;
        logic i_sra;
        logic i_jr;
        logic i_addi;
        logic i_andi;
        logic i_ori;
        logic i_xori;
        logic i_lui;
        logic i_lw;
        logic i_sw;
        logic i_beq;
        logic i_bne;
        logic i_j;
        logic i_jal;
    } inst_t;

endpackage

// File: rtl/mc_cu_if.sv
// mc_cu_if: IR/flag inputs and datapath control lines
// between the control unit (master) and datapath (slave).
interface mc_cu_if;

    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       mem_rdy;
    logic       pcwrite;
    logic       irwrite;
    logic       iord;
    logic       wmem;
    logic       wreg;
    logic       regrt;
    logic       m2reg;
    logic       jal;
    logic       sext;
    logic       shift;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;

    modport master (
        input  op, func, z, mem_rdy,
        output pcwrite, irwrite, iord, wmem, wreg, regrt, m2reg,
        output jal, sext, shift, alusrca, alusrcb, aluc, pcsource
    );

    modport slave (
        output op, func, z, mem_rdy,
        input  pcwrite, irwrite, iord, wmem, wreg, regrt, m2reg,
        input  jal, sext, shift, alusrca, alusrcb, aluc, pcsource
    );

endinterface

// File: rtl/mc_decode.sv
// mc_decode: op/func to one-hot instruction flags;
// ill is raised when no supported instruction matches.
module mc_decode
    import mc_cu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output inst_t      inst,
    output logic       ill
);

    logic rtype;

    assign rtype = (op == OP_R);

    always_comb begin
        inst        = '0;
        inst.i_add  = rtype && (func == FN_ADD);
        inst.i_sub  = rtype && (func == FN_SUB);
        inst.i_and  = rtype && (func == FN_AND);
        inst.i_or   = rtype && (func == FN_OR);
        inst.i_xor  = rtype && (func == FN_XOR);
        inst.i_sll  = rtype && (func == FN_SLL);
        inst.i_srl  = rtype && (func == FN_SRL);
        inst.i_sra  = rtype && (func == FN_SRA);
        inst.i_jr   = rtype && (func == FN_JR);
        inst.i_addi = (op == OP_ADDI);
        inst.i_andi = (op == OP_ANDI);
        inst.i_ori  = (op == OP_ORI);
        inst.i_xori = (op == OP_XORI);
        inst.i_lui  = (op == OP_LUI);
        inst.i_lw   = (op == OP_LW);
        inst.i_sw   = (op == OP_SW);
        inst.i_beq  = (op == OP_BEQ);
        inst.i_bne  = (op == OP_BNE);
        inst.i_j    = (op == OP_J);
        inst.i_jal  = (op == OP_JAL);
    end

    assign ill = (inst == '0);

endmodule

// File: rtl/mc_cu.sv
// mc_cu: multicycle IF/ID/EXE/MEM/WB control unit with
// memory-ready stalls, illegal-op flag and retire counter.
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter bit USE_MEM_RDY = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    mc_cu_if.master          bus,
    output logic [2:0]       state,
    output logic             ill_inst,
    output logic [CNT_W-1:0] inst_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t     state_q;
    state_t     state_d;
    inst_t      inst;
    logic       ill;
    logic       rdy;
    logic       ill_d;
    logic       retire;
    logic       rtype_alu;
    logic       itype_alu;
    logic [3:0] aluc_exe;

    mc_decode u_dec (
        .op   (bus.op),
        .func (bus.func),
        .inst (inst),
        .ill  (ill)
    );

    assign rdy = USE_MEM_RDY ? bus.mem_rdy : 1'b1;
    assign state = state_q;

    assign rtype_alu = inst.i_add | inst.i_sub | inst.i_and | inst.i_or
                     | inst.i_xor | inst.i_sll | inst.i_srl | inst.i_sra;
    assign itype_alu = inst.i_addi | inst.i_andi | inst.i_ori
                     | inst.i_xori | inst.i_lui;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IF;
            ill_inst <= 1'b0;
            inst_cnt <= '0;
        end else begin
            state_q  <= state_d;
            ill_inst <= ill_d;
            if (retire) inst_cnt <= inst_cnt + CNT_ONE;
        end
    end

    always_comb begin
        aluc_exe = ALU_ADD;
        unique case (1'b1)
            inst.i_sub, inst.i_beq, inst.i_bne: aluc_exe = ALU_SUB;
            inst.i_and, inst.i_andi:            aluc_exe = ALU_AND;
            inst.i_or,  inst.i_ori:             aluc_exe = ALU_OR;
            inst.i_xor, inst.i_xori:            aluc_exe = ALU_XOR;
            inst.i_lui:                         aluc_exe = ALU_LUI;
            inst.i_sll:                         aluc_exe = ALU_SLL;
            inst.i_srl:                         aluc_exe = ALU_SRL;
            inst.i_sra:                         aluc_exe = ALU_SRA;
            default:                            aluc_exe = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ill_d        = 1'b0;
        retire       = 1'b0;
        bus.pcwrite  = 1'b0;
        bus.irwrite  = 1'b0;
        bus.iord     = 1'b0;
        bus.wmem     = 1'b0;
        bus.wreg     = 1'b0;
        bus.regrt    = 1'b0;
        bus.m2reg    = 1'b0;
        bus.jal      = 1'b0;
        bus.sext     = 1'b0;
        bus.shift    = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = SRCB_REG;
        bus.aluc     = ALU_ADD;
        bus.pcsource = PCS_ALU;
        // reset masks every enable in the cycle it is held
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    bus.alusrcb = SRCB_FOUR;
                    if (rdy) begin
                        bus.irwrite = 1'b1;
                        bus.pcwrite = 1'b1;
                        state_d     = S_ID;
                    end
                end
                S_ID: begin
                    bus.alusrcb = SRCB_BR;
                    bus.sext    = 1'b1;
                    state_d     = S_EXE;
                    if (inst.i_j || inst.i_jal) begin
                        bus.pcwrite  = 1'b1;
                        bus.pcsource = PCS_JMP;
                        bus.wreg     = inst.i_jal;
                        bus.jal      = inst.i_jal;
                        state_d      = S_IF;
                        retire       = 1'b1;
                    end else if (inst.i_jr) begin
                        bus.pcwrite  = 1'b1;
                        bus.pcsource = PCS_REG;
                        state_d      = S_IF;
                        retire       = 1'b1;
                    end else if (ill) begin
                        ill_d   = 1'b1;
                        state_d = S_IF;
                    end
                end
                S_EXE: begin
                    bus.aluc = aluc_exe;
                    unique case (1'b1)
                        rtype_alu: begin
                            bus.alusrca = 1'b1;
                            bus.shift   = inst.i_sll | inst.i_srl | inst.i_sra;
                            state_d     = S_WB;
                        end
                        itype_alu: begin
                            bus.alusrca = 1'b1;
                            bus.alusrcb = SRCB_IMM;
                            bus.sext    = inst.i_addi;
                            state_d     = S_WB;
                        end
                        inst.i_lw, inst.i_sw: begin
                            bus.alusrca = 1'b1;
                            bus.alusrcb = SRCB_IMM;
                            bus.sext    = 1'b1;
                            state_d     = S_MEM;
                        end
                        inst.i_beq, inst.i_bne: begin
                            bus.alusrca  = 1'b1;
                            bus.pcwrite  = (inst.i_beq & bus.z)
                                         | (inst.i_bne & ~bus.z);
                            bus.pcsource = PCS_BR;
                            state_d      = S_IF;
                            retire       = 1'b1;
                        end
                        default: state_d = S_IF;
                    endcase
                end
                S_MEM: begin
                    bus.iord = 1'b1;
                    bus.wmem = inst.i_sw;
                    if (inst.i_sw) begin
                        if (rdy) begin
                            state_d = S_IF;
                            retire  = 1'b1;
                        end
                    end else if (inst.i_lw) begin
                        if (rdy) state_d = S_WB;
                    end else begin
                        state_d = S_IF;
                    end
                end
                S_WB: begin
                    bus.wreg  = 1'b1;
                    bus.m2reg = inst.i_lw;
                    bus.regrt = ~rtype_alu;
                    state_d   = S_IF;
                    retire    = 1'b1;
                end
                default: state_d = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: directed instruction traces for mc_cu, checked each
// cycle against a per-instruction step list built by the bench.
module tb_mc_cu;

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA, K_JR,
        K_ADDI, K_ANDI, K_ORI, K_XORI, K_LUI, K_LW, K_SW,
        K_BEQ, K_BNE, K_J, K_JAL, K_ILL_OP, K_ILL_FN
    } kind_t;

    typedef struct {
        bit         w, rst, rdy, zz, ret, ill;
        logic [5:0] op, fn;
        logic [2:0] st;
        logic       pcw, irw, wm, wr, jl;
        bit         c_iord, c_asa, c_asb, c_sx, c_sh, c_wb, c_pcs;
        logic       iord, asa, sx, sh, rt, m2;
        logic [1:0] asb, pcs;
        logic [3:0] alu, alm;
        int         lit_cnt, lit_ill;
    } step_t;

    typedef struct packed {
        logic [2:0]  st;
        logic        pcw, irw, iord, wm, wr, rt, m2, jl, sx, sh, asa;
        logic [1:0]  asb;
        logic [3:0]  alu;
        logic [1:0]  pcs;
        logic        ill;
        logic [31:0] cnt;
    } obs_t;

    logic        clock;
    logic        reset_a, reset_b;
    logic [5:0]  op, func;
    logic        z, rdy_a;
    logic [2:0]  st_a, st_b;
    logic        ill_a, ill_b;
    logic [31:0] cnt_a, cnt_b;
    obs_t        obs_a, obs_b, o;

    int          total, bad;
    step_t       q[$];
    step_t       exp_cur;
    bit          cv, which, tgt, pend_ill, ill_cur, cur_z;
    logic [31:0] exp_cnt, cnt_cur;
    logic [5:0]  cur_op, cur_fn;

    mc_cu_if bus_a();
    mc_cu_if bus_b();

    assign bus_a.op      = op;
    assign bus_a.func    = func;
    assign bus_a.z       = z;
    assign bus_a.mem_rdy = rdy_a;
    assign bus_b.op      = op;
    assign bus_b.func    = func;
    assign bus_b.z       = z;
    assign bus_b.mem_rdy = 1'b0;

    mc_cu #(.USE_MEM_RDY(1'b1), .CNT_W(32)) dut (
        .clock(clock), .reset(reset_a), .bus(bus_a),
        .state(st_a), .ill_inst(ill_a), .inst_cnt(cnt_a)
    );

    mc_cu #(.USE_MEM_RDY(1'b0), .CNT_W(32)) dut_nr (
        .clock(clock), .reset(reset_b), .bus(bus_b),
        .state(st_b), .ill_inst(ill_b), .inst_cnt(cnt_b)
    );

    assign obs_a = {st_a, bus_a.pcwrite, bus_a.irwrite, bus_a.iord,
                    bus_a.wmem, bus_a.wreg, bus_a.regrt, bus_a.m2reg,
                    bus_a.jal, bus_a.sext, bus_a.shift, bus_a.alusrca,
                    bus_a.alusrcb, bus_a.aluc, bus_a.pcsource, ill_a, cnt_a};
    assign obs_b = {st_b, bus_b.pcwrite, bus_b.irwrite, bus_b.iord,
                    bus_b.wmem, bus_b.wreg, bus_b.regrt, bus_b.m2reg,
                    bus_b.jal, bus_b.sext, bus_b.shift, bus_b.alusrca,
                    bus_b.alusrcb, bus_b.aluc, bus_b.pcsource, ill_b, cnt_b};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, got, want, $time);
        end
    endtask

    function automatic logic [11:0] enc(kind_t k);
        case (k)
            K_ADD:    return {6'b000000, 6'b100000};
            K_SUB:    return {6'b000000, 6'b100010};
            K_AND:    return {6'b000000, 6'b100100};
            K_OR:     return {6'b000000, 6'b100101};
            K_XOR:    return {6'b000000, 6'b100110};
            K_SLL:    return {6'b000000, 6'b000000};
            K_SRL:    return {6'b000000, 6'b000010};
            K_SRA:    return {6'b000000, 6'b000011};
            K_JR:     return {6'b000000, 6'b001000};
            K_ADDI:   return {6'b001000, 6'b000000};
            K_ANDI:   return {6'b001100, 6'b000000};
            K_ORI:    return {6'b001101, 6'b000000};
            K_XORI:   return {6'b001110, 6'b000000};
            K_LUI:    return {6'b001111, 6'b000000};
            K_LW:     return {6'b100011, 6'b000000};
            K_SW:     return {6'b101011, 6'b000000};
            K_BEQ:    return {6'b000100, 6'b000000};
            K_BNE:    return {6'b000101, 6'b000000};
            K_J:      return {6'b000010, 6'b000000};
            K_JAL:    return {6'b000011, 6'b000000};
            K_ILL_OP: return {6'b111111, 6'b000000};
            default:  return {6'b000000, 6'b000001};
        endcase
    endfunction

    // {care mask, value}; bit 3 is a don't-care for the x-prefixed ops
    function automatic logic [7:0] alu_of(kind_t k);
        case (k)
            K_SUB, K_BEQ, K_BNE: return {4'b0111, 4'b0100};
            K_AND, K_ANDI:       return {4'b0111, 4'b0001};
            K_OR, K_ORI:         return {4'b0111, 4'b0101};
            K_XOR, K_XORI:       return {4'b0111, 4'b0010};
            K_LUI:               return {4'b0111, 4'b0110};
            K_SLL:               return {4'b1111, 4'b0011};
            K_SRL:               return {4'b1111, 4'b0111};
            K_SRA:               return {4'b1111, 4'b1111};
            default:             return {4'b0111, 4'b0000};
        endcase
    endfunction

    function automatic step_t blank(logic [2:0] st);
        step_t s;
        s = '{default: 0};
        s.st = st;
        s.w = tgt;
        s.rdy = 1'b1;
        s.op = cur_op;
        s.fn = cur_fn;
        s.zz = cur_z;
        s.alm = 4'b0111;
        s.lit_cnt = -1;
        s.lit_ill = -1;
        return s;
    endfunction

    task automatic add_inst(kind_t k, bit zz, int ifw, int memw);
        step_t s;
        bit r_, i_, jmp, il, mem, br;
        {cur_op, cur_fn} = enc(k);
        cur_z = zz;
        r_  = k inside {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA};
        i_  = k inside {K_ADDI, K_ANDI, K_ORI, K_XORI, K_LUI};
        jmp = k inside {K_J, K_JAL, K_JR};
        il  = k inside {K_ILL_OP, K_ILL_FN};
        mem = k inside {K_LW, K_SW};
        br  = k inside {K_BEQ, K_BNE};
        for (int i = 0; i <= ifw; i++) begin
            s = blank(3'd0);
            s.c_iord = 1; s.c_asa = 1; s.c_asb = 1; s.c_pcs = 1;
            s.asb = 2'b01;
            s.rdy = (i == ifw);
            s.pcw = s.rdy;
            s.irw = s.rdy;
            q.push_back(s);
        end
        s = blank(3'd1);
        s.c_asa = 1; s.c_asb = 1; s.c_sx = 1;
        s.asb = 2'b11; s.sx = 1;
        if (k == K_J || k == K_JAL) begin
            s.pcw = 1; s.c_pcs = 1; s.pcs = 2'b11; s.ret = 1;
        end
        if (k == K_JAL) begin s.wr = 1; s.jl = 1; end
        if (k == K_JR) begin
            s.pcw = 1; s.c_pcs = 1; s.pcs = 2'b10; s.ret = 1;
        end
        s.ill = il;
        q.push_back(s);
        if (jmp || il) return;
        s = blank(3'd2);
        s.c_asb = 1;
        {s.alm, s.alu} = alu_of(k);
        if (r_) begin
            s.c_asa = 1; s.asa = 1; s.asb = 2'b00;
            s.c_sh = 1; s.sh = k inside {K_SLL, K_SRL, K_SRA};
        end else if (i_) begin
            s.asb = 2'b10; s.c_sx = 1; s.sx = (k == K_ADDI);
        end else if (mem) begin
            s.asb = 2'b10; s.c_sx = 1; s.sx = 1;
        end else begin
            s.c_asa = 1; s.asa = 1; s.asb = 2'b00;
            s.pcw = (k == K_BEQ) ? zz : !zz;
            s.c_pcs = 1; s.pcs = 2'b01; s.ret = 1;
        end
        q.push_back(s);
        if (br) return;
        if (mem) begin
            for (int i = 0; i <= memw; i++) begin
                s = blank(3'd3);
                s.c_iord = 1; s.iord = 1;
                s.wm = (k == K_SW);
                s.rdy = (i == memw);
                s.ret = (k == K_SW) && s.rdy;
                q.push_back(s);
            end
        end
        if (k == K_SW) return;
        s = blank(3'd4);
        s.wr = 1; s.c_wb = 1; s.rt = !r_; s.m2 = (k == K_LW); s.ret = 1;
        q.push_back(s);
    endtask

    task automatic push_rst(logic [2:0] st);
        step_t s;
        s = blank(st);
        s.rst = 1;
        q.push_back(s);
    endtask

    task automatic run_q();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(posedge clock); #1;
            if (s.w != which) begin exp_cnt = 0; pend_ill = 0; end
            which = s.w;
            op = s.op; func = s.fn; z = s.zz; rdy_a = s.rdy;
            reset_a = s.w ? 1'b0 : s.rst;
            reset_b = s.w ? s.rst : 1'b1;
            exp_cur = s; cnt_cur = exp_cnt; ill_cur = pend_ill; cv = 1;
            pend_ill = s.ill;
            if (s.rst) begin exp_cnt = 0; pend_ill = 0; end
            else if (s.ret) exp_cnt = exp_cnt + 1;
        end
    endtask

    always @(negedge clock) begin
        if (cv) begin
            o = which ? obs_b : obs_a;
            chk("state", {29'd0, o.st}, {29'd0, exp_cur.st});
            chk("pcwrite", {31'd0, o.pcw}, {31'd0, exp_cur.pcw});
            chk("irwrite", {31'd0, o.irw}, {31'd0, exp_cur.irw});
            chk("wmem", {31'd0, o.wm}, {31'd0, exp_cur.wm});
            chk("wreg", {31'd0, o.wr}, {31'd0, exp_cur.wr});
            chk("jal", {31'd0, o.jl}, {31'd0, exp_cur.jl});
            if (exp_cur.c_iord) chk("iord", {31'd0, o.iord}, {31'd0, exp_cur.iord});
            if (exp_cur.c_asa) chk("alusrca", {31'd0, o.asa}, {31'd0, exp_cur.asa});
            if (exp_cur.c_asb) begin
                chk("alusrcb", {30'd0, o.asb}, {30'd0, exp_cur.asb});
                chk("aluc", {28'd0, o.alu & exp_cur.alm},
                    {28'd0, exp_cur.alu & exp_cur.alm});
            end
            if (exp_cur.c_sx) chk("sext", {31'd0, o.sx}, {31'd0, exp_cur.sx});
            if (exp_cur.c_sh) chk("shift", {31'd0, o.sh}, {31'd0, exp_cur.sh});
            if (exp_cur.c_wb) begin
                chk("regrt", {31'd0, o.rt}, {31'd0, exp_cur.rt});
                chk("m2reg", {31'd0, o.m2}, {31'd0, exp_cur.m2});
            end
            if (exp_cur.c_pcs) chk("pcsource", {30'd0, o.pcs}, {30'd0, exp_cur.pcs});
            if (!exp_cur.rst) begin
                chk("ill_inst", {31'd0, o.ill}, {31'd0, ill_cur});
                chk("inst_cnt", o.cnt, cnt_cur);
            end
            if (exp_cur.lit_cnt >= 0) chk("lit_cnt", o.cnt, exp_cur.lit_cnt);
            if (exp_cur.lit_ill >= 0) chk("lit_ill", {31'd0, o.ill}, exp_cur.lit_ill);
        end
    end

    initial begin
        total = 0; bad = 0; cv = 0; which = 0; tgt = 0;
        exp_cnt = 0; pend_ill = 0; cur_op = 0; cur_fn = 0; cur_z = 0;
        reset_a = 1; reset_b = 1; op = 0; func = 0; z = 0; rdy_a = 0;
        @(posedge clock);
        push_rst(3'd0);
        run_q();

        add_inst(K_ADD, 0, 0, 0);
        chk("add_len", q.size(), 4);
        chk("add_seq", {20'd0, q[0].st, q[1].st, q[2].st, q[3].st}, 32'o0124);
        run_q();

        add_inst(K_LW, 0, 3, 2);
        chk("lw_len", q.size(), 10);
        q[0].lit_cnt = 1;
        run_q();

        add_inst(K_BEQ, 1, 0, 0);
        q[0].lit_cnt = 2;
        run_q();
        add_inst(K_BEQ, 0, 0, 0);
        q[0].lit_cnt = 3;
        run_q();

        add_inst(K_JAL, 0, 0, 0);
        chk("jal_len", q.size(), 2);
        q[0].lit_cnt = 4;
        run_q();

        add_inst(K_ILL_OP, 0, 0, 0);
        q[0].lit_cnt = 5;
        run_q();
        add_inst(K_SUB, 0, 1, 0);
        q[0].lit_ill = 1;
        q[0].lit_cnt = 5;
        q[1].lit_ill = 0;
        run_q();

        add_inst(K_SLL, 0, 0, 0);  run_q();
        add_inst(K_SRL, 0, 0, 0);  run_q();
        add_inst(K_SRA, 0, 0, 0);  run_q();
        add_inst(K_AND, 0, 0, 0);  run_q();
        add_inst(K_OR, 0, 0, 0);   run_q();
        add_inst(K_XOR, 0, 0, 0);  run_q();
        add_inst(K_ADDI, 0, 0, 0); run_q();
        add_inst(K_ANDI, 0, 0, 0); run_q();
        add_inst(K_ORI, 0, 0, 0);  run_q();
        add_inst(K_XORI, 0, 1, 0); run_q();
        add_inst(K_LUI, 0, 0, 0);  run_q();
        add_inst(K_SW, 0, 0, 1);   run_q();
        add_inst(K_BNE, 0, 0, 0);  run_q();
        add_inst(K_BNE, 1, 0, 0);  run_q();
        add_inst(K_J, 0, 0, 0);    run_q();
        add_inst(K_JR, 0, 0, 0);   run_q();
        add_inst(K_ILL_FN, 0, 0, 0); run_q();

        // abort a store mid-MEM with reset
        add_inst(K_SW, 0, 0, 2);
        void'(q.pop_back());
        void'(q.pop_back());
        push_rst(3'd3);
        run_q();
        add_inst(K_ADD, 0, 0, 0);
        q[0].lit_cnt = 0;
        run_q();

        tgt = 1;
        add_inst(K_LW, 0, 0, 0);
        chk("nr_lw_len", q.size(), 5);
        add_inst(K_ADD, 0, 0, 0);
        q[5].lit_cnt = 1;
        run_q();

        @(negedge clock); #1;
        cv = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_cu.md
Name: mc_cu

Overview:
Multicycle control unit for the MIPS-subset CPU, the successor to the single-cycle decoder. It is a state machine with the states IF, ID, EXE, MEM and WB. It sequences the shared memory, the IR/PC writes, the ALU operand selection and register writeback, and it stalls on a memory-ready handshake. It also flags illegal instructions and keeps a retired-instruction counter. It sits between the IR (which supplies op/func) and a multicycle datapath with a single shared memory port.

Parameters:
USE_MEM_RDY, 1, when 1 the IF and MEM states wait for mem_rdy; when 0 memory is single-cycle and mem_rdy is ignored (treated as 1).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  6  IR[31:26]; valid from ID onward
func  in  6  IR[5:0]; valid from ID onward
z  in  1  ALU zero flag (combinational, current cycle)
mem_rdy  in  1  memory access completes this cycle
pcwrite  out  1  PC load enable
irwrite  out  1  IR load enable
iord  out  1  memory address select: 0=PC, 1=ALUout
wmem  out  1  memory write
wreg  out  1  register file write
regrt  out  1  destination select: 1=rt, 0=rd
m2reg  out  1  writeback select: 1=memory data
jal  out  1  destination r31, data = PC
sext  out  1  immediate sign-extend (0 = zero-extend)
shift  out  1  ALU A operand = sa
alusrca  out  1  0=PC, 1=reg A
alusrcb  out  2  00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2
aluc  out  4  ALU op: add x000, sub x100, and x001, or x101, xor x010, lui x110, sll 0011, srl 0111, sra 1111
pcsource  out  2  00=ALU result, 01=ALUout (branch target), 10=reg A (jr), 11=jump address
state  out  3  current state (debug)
ill_inst  out  1  one-cycle pulse on illegal opcode/func
inst_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset:
  - state=IF, inst_cnt=0, ill_inst=0.
  - All combinational enables are 0 in the reset cycle, because reset overrides the decode.
  - Reset in any state aborts the instruction with no retire.
- Supported instructions: add sub and or xor sll srl sra jr addi andi ori xori lw sw beq bne lui j jal.
- Outputs are a combinational function of state, op, func and z, except ill_inst and inst_cnt, which are registered.
- IF:
  - iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - irwrite and pcwrite are asserted only when mem_rdy=1, then go to ID. Otherwise stay in IF with all enables low.
- ID:
  - alusrca=0, alusrcb=11, sext=1, aluc=add (branch target into ALUout).
  - j: pcwrite=1, pcsource=11, go to IF.
  - jal: the same, plus wreg=1, jal=1, go to IF.
  - jr: pcwrite=1, pcsource=10, go to IF.
  - Illegal op/func: ill_inst=1 on the next cycle, no writes, go to IF. This does not retire.
  - All others: go to EXE.
- EXE:
  - R-type ALU: alusrca=1, alusrcb=00, shift for sll/srl/sra, go to WB.
  - I-type ALU (addi/andi/ori/xori/lui): alusrcb=10; sext=1 only for addi; go to WB.
  - lw/sw: alusrcb=10, sext=1, aluc=add, go to MEM.
  - beq/bne: alusrca=1, alusrcb=00, aluc=sub. pcwrite = (beq&z)|(bne&~z), pcsource=01, go to IF.
- MEM:
  - iord=1.
  - sw: wmem=1 held for the whole MEM dwell; go to IF on mem_rdy.
  - lw: go to WB on mem_rdy.
- WB:
  - wreg=1, m2reg=lw.
  - regrt=1 for I-type and lw, 0 for R-type.
  - Go to IF.
- Retire:
  - inst_cnt increments by 1 on each transition into IF from ID (j/jal/jr), EXE (branch), MEM (sw) or WB.
  - It wraps modulo 2^CNT_W.
- The state register never holds an unused encoding; any unused encoding goes to IF.

Decomposition:
- Package mc_cu_pkg holds:
  - the state encoding constants (IF=0, ID=1, EXE=2, MEM=3, WB=4);
  - the opcode and func constants;
  - the aluc and alusrcb/pcsource constants.
- One sub-module, mc_decode: purely combinational op/func to one-hot instruction flags plus illegal. It is instantiated once.

Test Plan:
- Reset, then add (op=0, func=100000) with mem_rdy=1:
  - states IF,ID,EXE,WB,IF;
  - wreg=1 only in WB, regrt=0;
  - inst_cnt=1.
- lw with mem_rdy held low for 3 cycles in IF and 2 in MEM:
  - irwrite/pcwrite=0 while waiting, asserted the cycle mem_rdy=1;
  - WB has m2reg=1, regrt=1;
  - total 10 cycles.
- beq with z=1, then beq with z=0:
  - pcwrite=1, pcsource=01 in EXE for the first only;
  - both end in IF, inst_cnt +2.
- jal:
  - ID asserts pcwrite, pcsource=11, wreg=1, jal=1;
  - returns to IF after 2 cycles; no EXE.
- Illegal op=111111:
  - ill_inst pulses for exactly one cycle;
  - no wreg/wmem/pcwrite in ID;
  - inst_cnt unchanged.
- Reset asserted in MEM during sw:
  - next state IF, wmem=0, inst_cnt=0.
- Also run USE_MEM_RDY=0 with mem_rdy=0: lw still completes in 5 cycles.
